id_ex_reg: RTL
==============

Name: id_ex_reg

Overview:
- Pipeline register between the decode stage (register file read ports, immediate/control decode) and the execute stage.
- Captures decoded operands and control each cycle and bypasses a same-cycle writeback into the captured operands.
- Detects load-use hazards and inserts a bubble while stalling decode.
- Honours a downstream hold (`ex_stall`) and a branch/jump flush; counts inserted load-use bubbles for performance monitoring.

Parameters:
- XLEN, 32, datapath width of PC, immediate and operand fields.
- CNT_W, 16, width of the saturating load-use bubble counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-low.
- id_valid  in  1  decode holds a real instruction.
- id_pc  in  XLEN  PC of the decode instruction.
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_uses_rs1, id_uses_rs2  in  1 each  instruction actually reads that source.
- id_rs1_data, id_rs2_data  in  XLEN each  register file read data.
- id_imm  in  XLEN  decoded immediate.
- id_reg_write, id_mem_read, id_mem_write, id_alu_src  in  1 each  control bits.
- id_alu_op  in  4  ALU operation.
- wb_reg_write  in  1  writeback stage writes the register file this cycle.
- wb_rd  in  5  writeback destination.
- wb_data  in  XLEN  writeback data.
- ex_stall  in  1  execute stage cannot accept a new instruction; hold.
- flush  in  1  squash the decode instruction (taken branch/jump).
- ex_valid  out  1  EX register holds a real instruction.
- ex_pc, ex_imm, ex_rs1_data, ex_rs2_data  out  XLEN each  registered fields.
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered indices, used by the EX forwarding unit.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src  out  1 each  registered control.
- ex_alu_op  out  4  registered ALU op.
- id_stall  out  1  combinational; decode and fetch must hold their contents.
- bubble_count  out  CNT_W  number of load-use bubbles inserted, saturating.

Behaviour:
- Reset: while rst=0, every registered output is 0, including ex_valid, all control bits, all data fields and bubble_count. Reset takes effect immediately and asynchronously, including mid-stall and mid-flush.
- hazard (combinational) is true when all of the following hold:
  - ex_valid & ex_mem_read & (ex_rd≠0) & id_valid;
  - and either (id_uses_rs1 & id_rs1==ex_rd) or (id_uses_rs2 & id_rs2==ex_rd).
- id_stall = ~flush & (ex_stall | hazard).
- WB bypass: a captured operand is wb_data instead of id_rsN_data when wb_reg_write & wb_rd≠0 & wb_rd==id_rsN. This applies independently to rs1 and rs2. Index 0 is never bypassed, so captured data for x0 is whatever the register file supplies, which is zero.
- Per-edge update, highest priority first:
  1. flush=1: load a bubble.
  2. ex_stall=1: hold every EX field unchanged. No bypass is applied to held data; EX-side forwarding uses ex_rs1/ex_rs2.
  3. hazard=1: load a bubble and increment bubble_count.
  4. Otherwise: capture all id_* fields with the bypass applied; ex_valid←id_valid.
- Bubble definition: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src and ex_alu_op are all 0. ex_pc, ex_imm, data and index fields are also cleared to 0 for deterministic waveforms.
- id_valid=0 in the normal-capture case: controls are captured as given. Downstream gates them with ex_valid.
- bubble_count:
  - increments by 1 only in case 3;
  - at all-ones it stays all-ones;
  - never increments on a flush bubble or while ex_stall is held.
- Latency: exactly one cycle from ID inputs to EX outputs when not stalled. A load-use stall lasts exactly one cycle, because the next cycle the EX register holds a bubble with ex_mem_read=0.

Test Plan:
- Reset: drive rst=0 mid-run with ex_valid=1 -> all outputs 0 immediately, without waiting for a clock edge; bubble_count=0.
- Normal capture plus WB bypass: id_rs1=5, id_rs1_data=0x11, wb_reg_write=1, wb_rd=5, wb_data=0xABCD0000 -> next edge ex_rs1_data=0xABCD0000. Repeat with wb_rd=0 and id_rs1=0 -> ex_rs1_data=0x0 from the register file, no bypass.
- Load-use: EX holds lw to x7 (ex_mem_read=1, ex_rd=7); ID id_uses_rs2=1, id_rs2=7 ->
  - id_stall=1 for one cycle;
  - next edge ex_valid=0 and bubble_count=1;
  - following edge the ID instruction is captured with ex_valid=1 and id_stall=0.
  - Repeat with id_uses_rs2=0 -> no stall.
- Downstream hold: ex_stall=1 for 3 cycles with ID inputs changing -> EX outputs constant, id_stall=1, bubble_count unchanged.
- Flush priority: flush=1 together with ex_stall=1 and an active hazard -> id_stall=0; next edge ex_valid=0 with all control 0; bubble_count unchanged.
- Counter saturation: CNT_W=2, force 5 load-use bubbles -> bubble_count reads 1,2,3,3,3.

Source files
------------

// File: rtl/id_ex_reg.sv
// -----------------------------------------------------------------------------
// id_ex_reg
//
// Pipeline register between the decode (ID) and execute (EX) stages.
// Each cycle it captures the decoded operands and control bits, substitutes a
// same-cycle writeback value for a stale register-file read, detects load-use
// hazards (inserting a bubble and stalling decode), honours a downstream hold
// and a branch/jump flush, and counts load-use bubbles (saturating).
//
// Flow control:
//   ex_stall is the inverse of "EX ready": while it is high the EX register
//   holds every field and accepts nothing. id_stall is the inverse of "ID
//   ready": while it is high decode and fetch must keep their contents. A
//   decode instruction moves into EX on a rising edge only when flush=0,
//   ex_stall=0 and no load-use hazard is present.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   id_valid                 decode holds a real instruction
//   id_pc, id_imm            decode PC and immediate
//   id_rs1/id_rs2/id_rd      register indices
//   id_uses_rs1/id_uses_rs2  instruction really reads that source
//   id_rs1_data/id_rs2_data  register file read data
//   id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_alu_op  control
//   wb_reg_write, wb_rd, wb_data  writeback port (bypassed into operands)
//   ex_stall                 execute stage holds
//   flush                    squash the decode instruction
//   ex_*                     registered EX-stage fields
//   id_stall                 combinational stall request to decode/fetch
//   bubble_count             saturating count of load-use bubbles
// -----------------------------------------------------------------------------
module id_ex_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_alu_src,
    input  logic [3:0]       id_alu_op,

    input  logic             wb_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,

    input  logic             ex_stall,
    input  logic             flush,

    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_imm,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_alu_src,
    output logic [3:0]       ex_alu_op,

    output logic             id_stall,
    output logic [CNT_W-1:0] bubble_count
);

    // All EX-stage fields in one register so a bubble is simply '0.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            alu_src;
        logic [3:0]      alu_op;
    } ex_fields_t;

    ex_fields_t ex_q;
    ex_fields_t id_fields;

    logic            load_in_ex;
    logic            rs1_conflict;
    logic            rs2_conflict;
    logic            hazard;
    logic            wb_active;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    logic            cnt_full;

    // A load in EX only produces its data after the memory access, so any
    // decode instruction reading its destination must wait one cycle. x0 is
    // hardwired zero and never creates a dependency.
    always_comb begin
        load_in_ex   = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0);
        rs1_conflict = id_uses_rs1 & (id_rs1 == ex_q.rd);
        rs2_conflict = id_uses_rs2 & (id_rs2 == ex_q.rd);
        hazard       = load_in_ex & id_valid & (rs1_conflict | rs2_conflict);
    end

    // A flush discards the decode instruction, so stalling it would be
    // pointless and would keep the wrong-path instruction alive.
    assign id_stall = ~flush & (ex_stall | hazard);

    // The register file is read in the same cycle the writeback stage writes
    // it, so the read data may be stale; take the writeback value instead.
    always_comb begin
        wb_active = wb_reg_write & (wb_rd != 5'd0);
        rs1_fwd   = (wb_active && (wb_rd == id_rs1)) ? wb_data : id_rs1_data;
        rs2_fwd   = (wb_active && (wb_rd == id_rs2)) ? wb_data : id_rs2_data;
    end

    always_comb begin
        id_fields           = '0;
        id_fields.valid     = id_valid;
        id_fields.pc        = id_pc;
        id_fields.imm       = id_imm;
        id_fields.rs1_data  = rs1_fwd;
        id_fields.rs2_data  = rs2_fwd;
        id_fields.rs1       = id_rs1;
        id_fields.rs2       = id_rs2;
        id_fields.rd        = id_rd;
        id_fields.reg_write = id_reg_write;
        id_fields.mem_read  = id_mem_read;
        id_fields.mem_write = id_mem_write;
        id_fields.alu_src   = id_alu_src;
        id_fields.alu_op    = id_alu_op;
    end

    assign cnt_full = &bubble_count;

    // Priority: flush > downstream hold > load-use bubble > normal capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q         <= '0;
            bubble_count <= '0;
        end else if (flush) begin
            ex_q <= '0;
        end else if (ex_stall) begin
            // Held data is not re-bypassed; EX forwarding keys on ex_rs1/ex_rs2.
            ex_q <= ex_q;
        end else if (hazard) begin
            ex_q <= '0;
            if (!cnt_full) begin
                bubble_count <= bubble_count + CNT_W'(1);
            end
        end else begin
            ex_q <= id_fields;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_pc        = ex_q.pc;
    assign ex_imm       = ex_q.imm;
    assign ex_rs1_data  = ex_q.rs1_data;
    assign ex_rs2_data  = ex_q.rs2_data;
    assign ex_rs1       = ex_q.rs1;
    assign ex_rs2       = ex_q.rs2;
    assign ex_rd        = ex_q.rd;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_mem_write = ex_q.mem_write;
    assign ex_alu_src   = ex_q.alu_src;
    assign ex_alu_op    = ex_q.alu_op;

endmodule
